// File: rtl/intersection_traffic_model.sv
// intersection_traffic_model
// Closed-loop environment for the 5-lane traffic light controller. It keeps a
// vehicle queue per lane (e_str, w_str, e_left, w_left, ns). Vehicles arrive on
// pulse inputs and leave one at a time while their light is green. A sticky
// monitor flags illegal light combinations.
// Optional build macro TRAFFIC_WAIT_STATS_EN adds per-lane head-of-line wait
// statistics: the max_wait and starve ports.

package light_package;
    typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2} color_t;
endpackage

module intersection_traffic_model
    import light_package::*;
#(
    parameter int QW            = 4,
    parameter int MAX_Q         = 15,
    parameter int DEPART_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      arrive,
    input  color_t          e_str_light,
    input  color_t          w_str_light,
    input  color_t          e_left_light,
    input  color_t          w_left_light,
    input  color_t          ns_light,
    output logic            e_str_sensor,
    output logic            w_str_sensor,
    output logic            e_left_sensor,
    output logic            w_left_sensor,
    output logic            ns_sensor,
    output logic [5*QW-1:0] q_count,
    output logic [4:0]      depart,
    output logic [15:0]     depart_total,
    output logic            overflow,
    output logic            conflict_error,
    output logic [4:0]      conflict_lanes
`ifdef TRAFFIC_WAIT_STATS_EN
    ,
    output logic [5*16-1:0] max_wait,
    output logic [4:0]      starve
`endif
);

    localparam int            TW     = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [QW-1:0] Q_MAX  = QW'(MAX_Q);

    // Lane-indexed view of the five light inputs
    color_t          light [5];
    logic [QW-1:0]   q_q   [5];
    logic [QW-1:0]   q_d   [5];
    logic [TW-1:0]   t_q   [5];
    logic [TW-1:0]   t_d   [5];
    logic [15:0]     tot_q, tot_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic [4:0]      lanes_q, lanes_d;
    logic [4:0]      dep;
    logic [4:0]      active;
    logic            legal;

    assign light[0] = e_str_light;
    assign light[1] = w_str_light;
    assign light[2] = e_left_light;
    assign light[3] = w_left_light;
    assign light[4] = ns_light;

    // Departure timing and queue next-state for every lane. The timer counts
    // green cycles spent on the head vehicle; any non-green cycle or an empty
    // queue throws away partial progress.
    always_comb begin
        ovf_d = ovf_q;
        for (int l = 0; l < 5; l++) begin
            dep[l] = 1'b0;
            t_d[l] = '0;
            q_d[l] = q_q[l];
            if (!reset && light[l] == GREEN && q_q[l] != '0) begin
                if (t_q[l] == T_LAST) begin
                    dep[l] = 1'b1;
                end else begin
                    t_d[l] = t_q[l] + TW'(1);
                end
            end
            if (arrive[l] && !dep[l]) begin
                if (q_q[l] == Q_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d[l] = q_q[l] + QW'(1);
                end
            end else if (!arrive[l] && dep[l]) begin
                q_d[l] = q_q[l] - QW'(1);
            end
        end
    end

    // Running departure total, adding the popcount of this cycle's departures
    always_comb begin
        tot_d = tot_q;
        for (int l = 0; l < 5; l++) begin
            tot_d = tot_d + {15'd0, dep[l]};
        end
    end

    // Conflict monitor: the non-red lanes must fit inside one legal phase.
    // The first illegal vector is captured and held until reset.
    always_comb begin
        for (int l = 0; l < 5; l++) begin
            active[l] = (light[l] != RED);
        end
        legal = ((active & ~5'b00011) == 5'b0) ||
                ((active & ~5'b00101) == 5'b0) ||
                ((active & ~5'b01010) == 5'b0) ||
                ((active & ~5'b01100) == 5'b0) ||
                ((active & ~5'b10000) == 5'b0);
        err_d   = err_q;
        lanes_d = lanes_q;
        if (!legal && !err_q) begin
            err_d   = 1'b1;
            lanes_d = active;
        end
    end

    // State registers; reset takes priority over every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 5; l++) begin
                q_q[l] <= '0;
                t_q[l] <= '0;
            end
            tot_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            lanes_q <= '0;
        end else begin
            for (int l = 0; l < 5; l++) begin
                q_q[l] <= q_d[l];
                t_q[l] <= t_d[l];
            end
            tot_q   <= tot_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            lanes_q <= lanes_d;
        end
    end

    // Output packing; sensors follow the registered queue depth
    always_comb begin
        q_count = '0;
        for (int l = 0; l < 5; l++) begin
            q_count[l*QW +: QW] = q_q[l];
        end
    end

    assign e_str_sensor   = (q_q[0] != '0);
    assign w_str_sensor   = (q_q[1] != '0);
    assign e_left_sensor  = (q_q[2] != '0);
    assign w_left_sensor  = (q_q[3] != '0);
    assign ns_sensor      = (q_q[4] != '0);
    assign depart         = dep;
    assign depart_total   = tot_q;
    assign overflow       = ovf_q;
    assign conflict_error = err_q;
    assign conflict_lanes = lanes_q;

`ifdef TRAFFIC_WAIT_STATS_EN
    logic [15:0] w_q [5];
    logic [15:0] w_d [5];
    logic [15:0] m_q [5];
    logic [15:0] m_d [5];

    // Head-of-line wait: saturating count while a vehicle is held; the peak
    // is tracked against the next wait value so both update on the same edge
    always_comb begin
        for (int l = 0; l < 5; l++) begin
            w_d[l] = '0;
            if (q_q[l] != '0 && !dep[l]) begin
                w_d[l] = (w_q[l] == 16'hFFFF) ? w_q[l] : w_q[l] + 16'd1;
            end
            m_d[l] = (w_d[l] > m_q[l]) ? w_d[l] : m_q[l];
        end
    end

    // Wait statistic registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 5; l++) begin
                w_q[l] <= '0;
                m_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 5; l++) begin
                w_q[l] <= w_d[l];
                m_q[l] <= m_d[l];
            end
        end
    end

    // Statistic output packing
    always_comb begin
        max_wait = '0;
        starve   = '0;
        for (int l = 0; l < 5; l++) begin
            max_wait[l*16 +: 16] = m_q[l];
            starve[l]            = (w_q[l] >= 16'd1024);
        end
    end
`endif

endmodule

// File: tb/tb_intersection_traffic_model.sv
module tb_intersection_traffic_model;
    import light_package::*;

    localparam int QW    = 4;
    localparam int MAX_Q = 15;
    localparam int DC    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    arrive = '0;
    color_t        lt [5];
    color_t        nl [5];
    logic          s_es, s_ws, s_el, s_wl, s_ns;
    logic [5*QW-1:0] q_count;
    logic [4:0]    depart;
    logic [15:0]   depart_total;
    logic          overflow, conflict_error;
    logic [4:0]    conflict_lanes;
`ifdef TRAFFIC_WAIT_STATS_EN
    logic [79:0]   max_wait;
    logic [4:0]    starve;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state (plain integers)
    int mq [5];
    int mp [5];
    int mw [5];
    int mmax [5];
    int mtot, mov, merr, mlanes;

    always #5 clk = ~clk;

    intersection_traffic_model #(.QW(QW), .MAX_Q(MAX_Q), .DEPART_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .arrive         (arrive),
        .e_str_light    (lt[0]),
        .w_str_light    (lt[1]),
        .e_left_light   (lt[2]),
        .w_left_light   (lt[3]),
        .ns_light       (lt[4]),
        .e_str_sensor   (s_es),
        .w_str_sensor   (s_ws),
        .e_left_sensor  (s_el),
        .w_left_sensor  (s_wl),
        .ns_sensor      (s_ns),
        .q_count        (q_count),
        .depart         (depart),
        .depart_total   (depart_total),
        .overflow       (overflow),
        .conflict_error (conflict_error),
        .conflict_lanes (conflict_lanes)
`ifdef TRAFFIC_WAIT_STATS_EN
        ,
        .max_wait       (max_wait),
        .starve         (starve)
`endif
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Allowed non-red vectors, listed explicitly
    function automatic bit is_legal(input logic [4:0] a);
        logic [4:0] ok [10];
        ok = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
               5'b10000, 5'b00011, 5'b00101, 5'b01010, 5'b01100};
        foreach (ok[k]) if (ok[k] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic all_red();
        for (int i = 0; i < 5; i++) nl[i] = RED;
    endtask

    // One clock cycle: drive, predict, compare, then advance the model
    task automatic tick(input logic rst_v, input logic [4:0] arr_v);
        logic [4:0]      edep, esens, act;
        logic [5*QW-1:0] eq;
        logic [79:0]     emax;
        logic [4:0]      estarve;
        int              npop;
        @(posedge clk);
        #1;
        reset  = rst_v;
        arrive = arr_v;
        for (int i = 0; i < 5; i++) lt[i] = nl[i];
        edep = '0;
        for (int i = 0; i < 5; i++)
            if (!rst_v && lt[i] == GREEN && mq[i] > 0 && mp[i] + 1 == DC) edep[i] = 1'b1;
        eq = '0; esens = '0; emax = '0; estarve = '0;
        for (int i = 0; i < 5; i++) begin
            eq[i*QW +: QW]  = QW'(mq[i]);
            esens[i]        = (mq[i] != 0);
            emax[i*16 +: 16] = 16'(mmax[i]);
            estarve[i]      = (mw[i] >= 1024);
        end
        @(negedge clk);
        chk("q_count", 80'(q_count), 80'(eq));
        chk("sensors", 80'({s_ns, s_wl, s_el, s_ws, s_es}), 80'(esens));
        chk("depart", 80'(depart), 80'(edep));
        chk("depart_total", 80'(depart_total), 80'(mtot));
        chk("overflow", 80'(overflow), 80'(mov));
        chk("conflict_error", 80'(conflict_error), 80'(merr));
        chk("conflict_lanes", 80'(conflict_lanes), 80'(mlanes));
`ifdef TRAFFIC_WAIT_STATS_EN
        chk("max_wait", max_wait, emax);
        chk("starve", 80'(starve), 80'(estarve));
`endif
        if (rst_v) begin
            for (int i = 0; i < 5; i++) begin
                mq[i] = 0; mp[i] = 0; mw[i] = 0; mmax[i] = 0;
            end
            mtot = 0; mov = 0; merr = 0; mlanes = 0;
        end else begin
            npop = 0;
            for (int i = 0; i < 5; i++) begin
                if (mq[i] > 0 && !edep[i]) mw[i] = (mw[i] < 65535) ? mw[i] + 1 : 65535;
                else mw[i] = 0;
                if (mw[i] > mmax[i]) mmax[i] = mw[i];
                if (lt[i] == GREEN && mq[i] > 0) mp[i] = edep[i] ? 0 : mp[i] + 1;
                else mp[i] = 0;
                if (arr_v[i] && !edep[i]) begin
                    if (mq[i] == MAX_Q) mov = 1;
                    else mq[i]++;
                end else if (!arr_v[i] && edep[i]) begin
                    mq[i]--;
                end
                npop += int'(edep[i]);
            end
            mtot = (mtot + npop) % 65536;
            for (int i = 0; i < 5; i++) act[i] = (lt[i] != RED);
            if (!is_legal(act) && merr == 0) begin
                merr   = 1;
                mlanes = int'(act);
            end
        end
    endtask

    initial begin
        logic [4:0] phases [5];
        logic [4:0] ph;
        int         hold;
        phases = '{5'b00011, 5'b00101, 5'b01010, 5'b01100, 5'b10000};
        for (int i = 0; i < 5; i++) begin
            lt[i] = RED; nl[i] = RED;
            mq[i] = 0; mp[i] = 0; mw[i] = 0; mmax[i] = 0;
        end
        mtot = 0; mov = 0; merr = 0; mlanes = 0;

        // Reset and three arrivals on e_str with all lights red
        all_red();
        tick(1, 0); tick(1, 0);
        chk("reset_q", 80'(q_count), 80'd0);
        tick(0, 5'b00001); tick(0, 5'b00001); tick(0, 5'b00001);
        tick(0, 0);
        chk("estr_q3", 80'(q_count[3:0]), 80'd3);

        // e_str green for six cycles drains the queue
        nl[0] = GREEN;
        for (int c = 0; c < 6; c++) tick(0, 0);
        all_red();
        tick(0, 0);
        chk("estr_total3", 80'(depart_total), 80'd3);
        chk("estr_empty", 80'(s_es), 80'd0);

        // ns: green one cycle, yellow, then green again
        tick(0, 5'b10000); tick(0, 5'b10000);
        nl[4] = GREEN;  tick(0, 0);
        nl[4] = YELLOW; tick(0, 0); tick(0, 0);
        chk("ns_no_depart", 80'(depart_total), 80'd3);
        nl[4] = GREEN;  tick(0, 0); tick(0, 0); tick(0, 0); tick(0, 0);
        all_red(); tick(0, 0);
        chk("ns_total5", 80'(depart_total), 80'd5);

        // w_left saturation, then simultaneous arrive and depart at the limit
        for (int c = 0; c < 16; c++) tick(0, 5'b01000);
        tick(0, 0);
        chk("wleft_q15", 80'(q_count[15:12]), 80'd15);
        chk("wleft_ovf", 80'(overflow), 80'd1);
        nl[3] = GREEN;
        for (int c = 0; c < 4; c++) tick(0, 5'b01000);
        all_red(); tick(0, 0);
        chk("wleft_hold15", 80'(q_count[15:12]), 80'd15);

        // Conflict capture and hold
        nl[2] = GREEN; nl[4] = GREEN; tick(0, 0);
        all_red(); tick(0, 0);
        chk("conf_err", 80'(conflict_error), 80'd1);
        chk("conf_lanes", 80'(conflict_lanes), 80'h14);
        nl[0] = GREEN; nl[3] = GREEN; tick(0, 0);
        all_red(); tick(0, 0);
        chk("conf_hold", 80'(conflict_lanes), 80'h14);
        tick(1, 0); tick(0, 0);
        chk("conf_reset", 80'({conflict_error, conflict_lanes}), 80'd0);

        // Long red on a single ns vehicle
        tick(0, 5'b10000);
        for (int c = 0; c < 1105; c++) tick(0, 0);
`ifdef TRAFFIC_WAIT_STATS_EN
        chk("ns_maxwait", 80'(max_wait[79:64] >= 16'd1100), 80'd1);
        chk("ns_starve1", 80'(starve[4]), 80'd1);
`endif
        nl[4] = GREEN; tick(0, 0); tick(0, 0); tick(0, 0);
        all_red(); tick(0, 0);
`ifdef TRAFFIC_WAIT_STATS_EN
        chk("ns_starve0", 80'(starve[4]), 80'd0);
`endif

        // Randomized traffic: mostly legal phases, occasional illegal mixes and resets
        hold = 0;
        ph   = 5'b00011;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(4, 20);
                if ($urandom_range(0, 199) == 0) ph = 5'($urandom);
                else ph = phases[$urandom_range(0, 4)];
                for (int i = 0; i < 5; i++)
                    nl[i] = ph[i] ? color_t'($urandom_range(0, 2)) : RED;
            end
            hold--;
            tick(($urandom_range(0, 499) == 0), 5'($urandom & $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
